// File: rtl/result_encoder_if.sv
// Result-side bus between the execution units/CPU and result_encoder.
// The master modport drives unit completions and the CPU ack; the slave is the encoder.
interface result_encoder_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          add_done;
    logic [31:0]   add_result;
    logic          mul_done;
    logic [31:0]   mul_result;
    logic          sine_done;
    logic [31:0]   sine_result;
    logic          cpu_ack;
    logic [31:0]   result_out;
    logic [1:0]    result_src;
    logic          result_valid;
    logic          out_fifo_hold;
    logic          overflow_err;
    logic [CW-1:0] fifo_count;

    modport master (
        output add_done, add_result, mul_done, mul_result,
               sine_done, sine_result, cpu_ack,
        input  result_out, result_src, result_valid,
               out_fifo_hold, overflow_err, fifo_count
    );

    modport slave (
        input  add_done, add_result, mul_done, mul_result,
               sine_done, sine_result, cpu_ack,
        output result_out, result_src, result_valid,
               out_fifo_hold, overflow_err, fifo_count
    );
endinterface

// File: rtl/result_encoder.sv
// Collects add/mul/sine results through one-entry holding registers into a
// result FIFO read by the CPU with an asynchronous strobe/acknowledge.
module result_encoder #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned HOLD_LEVEL = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    result_encoder_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_CNT  = CW'(HOLD_LEVEL);

    typedef enum logic [1:0] {
        SRC_ADD  = 2'b00,
        SRC_MUL  = 2'b01,
        SRC_SINE = 2'b10
    } src_e;

    logic [33:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_hold_add;
    logic [31:0]   r_hold_mul;
    logic [31:0]   r_hold_sine;
    logic          r_hv_add;
    logic          r_hv_mul;
    logic          r_hv_sine;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_overflow;

    logic          w_ack_edge;
    logic          w_pop;
    logic          w_can_push;
    logic          w_drain_add;
    logic          w_drain_mul;
    logic          w_drain_sine;
    logic          w_push;
    logic [33:0]   w_wdata;
    logic          w_empty;

    assign w_ack_edge   = r_sync1 & ~r_sync2;
    assign w_empty      = (r_count == '0);
    assign w_pop        = w_ack_edge & ~w_empty;
    // A same-edge pop frees a slot even when the FIFO is full.
    assign w_can_push   = (r_count < DEPTH_CNT) | w_pop;
    assign w_drain_add  = w_can_push & r_hv_add;
    assign w_drain_mul  = w_can_push & r_hv_mul & ~r_hv_add;
    assign w_drain_sine = w_can_push & r_hv_sine & ~r_hv_add & ~r_hv_mul;
    assign w_push       = w_drain_add | w_drain_mul | w_drain_sine;

    always_comb begin
        w_wdata = '0;
        if (r_hv_add) begin
            w_wdata = {SRC_ADD, r_hold_add};
        end else if (r_hv_mul) begin
            w_wdata = {SRC_MUL, r_hold_mul};
        end else if (r_hv_sine) begin
            w_wdata = {SRC_SINE, r_hold_sine};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hold_add  <= '0;
            r_hold_mul  <= '0;
            r_hold_sine <= '0;
            r_hv_add    <= 1'b0;
            r_hv_mul    <= 1'b0;
            r_hv_sine   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (bus.add_done) begin
                if (r_hv_add && !w_drain_add) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_hold_add <= bus.add_result;
                    r_hv_add   <= 1'b1;
                end
            end else if (w_drain_add) begin
                r_hv_add <= 1'b0;
            end

            if (bus.mul_done) begin
                if (r_hv_mul && !w_drain_mul) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_hold_mul <= bus.mul_result;
                    r_hv_mul   <= 1'b1;
                end
            end else if (w_drain_mul) begin
                r_hv_mul <= 1'b0;
            end

            if (bus.sine_done) begin
                if (r_hv_sine && !w_drain_sine) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_hold_sine <= bus.sine_result;
                    r_hv_sine   <= 1'b1;
                end
            end else if (w_drain_sine) begin
                r_hv_sine <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_sync1 <= bus.cpu_ack;
            r_sync2 <= r_sync1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible when fifo_count > 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    assign bus.result_out    = w_empty ? '0 : r_mem[r_rd_ptr][31:0];
    assign bus.result_src    = w_empty ? '0 : r_mem[r_rd_ptr][33:32];
    assign bus.result_valid  = ~w_empty;
    assign bus.out_fifo_hold = (r_count >= HOLD_CNT);
    assign bus.overflow_err  = r_overflow;
    assign bus.fifo_count    = r_count;
endmodule

// File: tb/tb_result_encoder.sv
// Directed bench for result_encoder: capture, arbitration, FIFO wrap,
// ack synchronisation, overflow and asynchronous reset.
module tb_result_encoder;
    logic clk;
    logic n_rst;
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned max_count;
    logic [33:0] exp_q [$];

    result_encoder_if #(.DEPTH(8)) bus ();

    result_encoder #(.DEPTH(8), .HOLD_LEVEL(6)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (n_rst && (int'(bus.fifo_count) > max_count)) begin
            max_count = int'(bus.fifo_count);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned src, input logic [31:0] v);
        case (src)
            0: begin bus.add_done  = 1'b1; bus.add_result  = v; end
            1: begin bus.mul_done  = 1'b1; bus.mul_result  = v; end
            default: begin bus.sine_done = 1'b1; bus.sine_result = v; end
        endcase
        tick();
        bus.add_done  = 1'b0;
        bus.mul_done  = 1'b0;
        bus.sine_done = 1'b0;
    endtask

    task automatic ack_pop();
        bus.cpu_ack = 1'b1;
        repeat (2) tick();
        bus.cpu_ack = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_head(input string tag, input logic [1:0] src, input logic [31:0] v);
        check({tag, "_data"}, 64'(bus.result_out), 64'(v));
        check({tag, "_src"},  64'(bus.result_src), 64'(src));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.add_done = 1'b0; bus.add_result = '0;
        bus.mul_done = 1'b0; bus.mul_result = '0;
        bus.sine_done = 1'b0; bus.sine_result = '0;
        bus.cpu_ack = 1'b0;
        n_rst = 1'b0;
        repeat (3) tick();
        check("rst_count", 64'(bus.fifo_count), 64'd0);
        check("rst_valid", 64'(bus.result_valid), 64'd0);
        check("rst_hold", 64'(bus.out_fifo_hold), 64'd0);
        check("rst_out", 64'(bus.result_out), 64'd0);
        check("rst_ovf", 64'(bus.overflow_err), 64'd0);
        n_rst = 1'b1;
        tick();

        // 1: single add result and ack latency
        push(0, 32'h3F80_0000);
        check("t1_valid_e", 64'(bus.result_valid), 64'd0);
        tick();
        check("t1_valid", 64'(bus.result_valid), 64'd1);
        check_head("t1_head", 2'b00, 32'h3F80_0000);
        check("t1_count", 64'(bus.fifo_count), 64'd1);
        bus.cpu_ack = 1'b1;
        tick();
        check("t1_cnt_a", 64'(bus.fifo_count), 64'd1);
        tick();
        check("t1_cnt_a1", 64'(bus.fifo_count), 64'd0);
        check("t1_valid_a1", 64'(bus.result_valid), 64'd0);
        check("t1_out_empty", 64'(bus.result_out), 64'd0);
        bus.cpu_ack = 1'b0;
        repeat (2) tick();

        // 2: simultaneous completions drain in priority order
        bus.add_done = 1'b1;  bus.add_result  = 32'h1;
        bus.mul_done = 1'b1;  bus.mul_result  = 32'h2;
        bus.sine_done = 1'b1; bus.sine_result = 32'h3;
        tick();
        bus.add_done = 1'b0; bus.mul_done = 1'b0; bus.sine_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t2_count", 64'(bus.fifo_count), 64'(k));
        end
        check("t2_ovf", 64'(bus.overflow_err), 64'd0);
        check_head("t2_h0", 2'b00, 32'h1);
        ack_pop();
        check_head("t2_h1", 2'b01, 32'h2);
        ack_pop();
        check_head("t2_h2", 2'b10, 32'h3);
        ack_pop();
        check("t2_empty", 64'(bus.fifo_count), 64'd0);

        // 3: fill, hold threshold, holding register and overrun
        for (int k = 1; k <= 9; k++) begin
            push(0, 32'h100 + 32'(k));
            check("t3_count", 64'(bus.fifo_count), 64'(k - 1));
            check("t3_fhold", 64'(bus.out_fifo_hold), 64'((k - 1) >= 6));
        end
        tick();
        check("t3_full", 64'(bus.fifo_count), 64'd8);
        check("t3_fhold_full", 64'(bus.out_fifo_hold), 64'd1);
        check("t3_ovf0", 64'(bus.overflow_err), 64'd0);
        check_head("t3_h1", 2'b00, 32'h101);
        push(0, 32'h10A);
        check("t3_ovf1", 64'(bus.overflow_err), 64'd1);
        ack_pop();
        check("t3_cnt_after_ack", 64'(bus.fifo_count), 64'd8);
        for (int k = 2; k <= 9; k++) begin
            check_head("t3_drain", 2'b00, 32'h100 + 32'(k));
            ack_pop();
        end
        check("t3_drained", 64'(bus.fifo_count), 64'd0);
        check("t3_ovf_sticky", 64'(bus.overflow_err), 64'd1);

        // 4: interleaved push/pop across pointer wrap
        max_count = 0;
        for (int i = 0; i < 20; i++) begin
            push(i % 3, 32'hA000_0000 + 32'(i));
            tick();
            exp_q.push_back({2'(i % 3), 32'hA000_0000 + 32'(i)});
            if (i > 0) begin
                check_head("t4_head", exp_q[0][33:32], exp_q[0][31:0]);
                ack_pop();
                void'(exp_q.pop_front());
            end
        end
        check_head("t4_last", exp_q[0][33:32], exp_q[0][31:0]);
        ack_pop();
        void'(exp_q.pop_front());
        check("t4_empty", 64'(bus.fifo_count), 64'd0);
        check("t4_max", 64'(max_count), 64'd2);

        // 5: held ack pops once; acks on empty FIFO are ignored
        push(0, 32'h51);
        push(1, 32'h52);
        push(2, 32'h53);
        tick();
        check("t5_count3", 64'(bus.fifo_count), 64'd3);
        bus.cpu_ack = 1'b1;
        repeat (10) tick();
        check("t5_held", 64'(bus.fifo_count), 64'd2);
        bus.cpu_ack = 1'b0;
        repeat (2) tick();
        check_head("t5_h1", 2'b01, 32'h52);
        ack_pop();
        check_head("t5_h2", 2'b10, 32'h53);
        ack_pop();
        for (int k = 0; k < 3; k++) ack_pop();
        check("t5_empty_cnt", 64'(bus.fifo_count), 64'd0);
        check("t5_empty_valid", 64'(bus.result_valid), 64'd0);
        push(1, 32'h5A);
        tick();
        check("t5_after_cnt", 64'(bus.fifo_count), 64'd1);
        check_head("t5_after", 2'b01, 32'h5A);
        ack_pop();

        // 6: asynchronous reset with queued entries and a pending hold
        for (int k = 0; k < 5; k++) push(0, 32'h600 + 32'(k));
        tick();
        check("t6_count5", 64'(bus.fifo_count), 64'd5);
        push(1, 32'h6FF);
        #2 n_rst = 1'b0;
        #1;
        check("t6_rst_count", 64'(bus.fifo_count), 64'd0);
        check("t6_rst_valid", 64'(bus.result_valid), 64'd0);
        check("t6_rst_out", 64'(bus.result_out), 64'd0);
        check("t6_rst_src", 64'(bus.result_src), 64'd0);
        check("t6_rst_fhold", 64'(bus.out_fifo_hold), 64'd0);
        check("t6_rst_ovf", 64'(bus.overflow_err), 64'd0);
        tick();
        n_rst = 1'b1;
        repeat (2) tick();
        check("t6_no_mul", 64'(bus.fifo_count), 64'd0);
        push(0, 32'hBEEF);
        tick();
        check("t6_count1", 64'(bus.fifo_count), 64'd1);
        check_head("t6_first", 2'b00, 32'hBEEF);
        tick();
        check("t6_count_still1", 64'(bus.fifo_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
